// File: rtl/enc_74148_sync.sv
// Clocked 74148-style 8-to-3 priority encoder with valid/ack hold and per-line masking.
// Optional macro ENC74148_ACK_COUNT_EN adds a saturating accepted-ack counter on ack_cnt_o.
module enc_74148_sync #(
    parameter int NUM_SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] in_n_i,
    input  logic       ei_n_i,
    input  logic       ack_i,
    output logic [2:0] a_n_o,
    output logic       gs_n_o,
    output logic       eo_n_o,
    output logic       valid_o
`ifdef ENC74148_ACK_COUNT_EN
    ,
    output logic [7:0] ack_cnt_o
`endif
);

    // state | meaning
    // IDLE  | searching for the highest unmasked request
    // HOLD  | code frozen on a_n_o, waiting for ack or abort
    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state_q;
    logic [2:0] code_q;
    logic [7:0] mask_q;
    logic [7:0] in_s;
    logic [7:0] req;
    logic [7:0] ack_set;
    logic [7:0] mask_nxt;
    logic [2:0] prio;
    logic       req_any;
    logic       ack_take;

    generate
        if (NUM_SYNC_STAGES == 0) begin : g_bypass
            assign in_s = in_n_i;
        end else begin : g_sync
            logic [7:0] sync_q [NUM_SYNC_STAGES];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < NUM_SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
                end else begin
                    sync_q[0] <= in_n_i;
                    for (int i = 1; i < NUM_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign in_s = sync_q[NUM_SYNC_STAGES-1];
        end
    endgenerate

    assign req      = ~in_s & ~mask_q;
    assign ack_take = (state_q == HOLD) && ack_i;

    // Ascending scan so the highest set index is the one left standing.
    always_comb begin
        prio    = 3'd0;
        req_any = |req;
        for (int k = 0; k < 8; k++) begin
            if (req[k]) prio = 3'(k);
        end
    end

    // A released line always clears its mask bit, even in the cycle it is acked.
    assign ack_set  = (ack_take && !in_s[code_q]) ? (8'h01 << code_q) : 8'h00;
    assign mask_nxt = (mask_q | ack_set) & ~in_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            code_q  <= 3'd0;
            mask_q  <= 8'h00;
            a_n_o   <= 3'b111;
            gs_n_o  <= 1'b1;
            eo_n_o  <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            mask_q <= mask_nxt;
            case (state_q)
                IDLE: begin
                    if (!ei_n_i && req_any) begin
                        state_q <= HOLD;
                        code_q  <= prio;
                        a_n_o   <= ~prio;
                        gs_n_o  <= 1'b0;
                        valid_o <= 1'b1;
                        eo_n_o  <= 1'b1;
                    end else begin
                        a_n_o   <= 3'b111;
                        gs_n_o  <= 1'b1;
                        valid_o <= 1'b0;
                        eo_n_o  <= ei_n_i;
                    end
                end
                HOLD: begin
                    if (ack_i || ei_n_i) begin
                        state_q <= IDLE;
                        a_n_o   <= 3'b111;
                        gs_n_o  <= 1'b1;
                        valid_o <= 1'b0;
                        eo_n_o  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ENC74148_ACK_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_cnt_o <= 8'h00;
        end else if (ack_take && ack_cnt_o != 8'hFF) begin
            ack_cnt_o <= ack_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: doc/enc_74148_sync.md
Name: enc_74148_sync

Overview:
- Clocked 8-to-3 priority encoder with 74148 truth table. It is the encoding counterpart to the 74138 decoder family.
- Takes eight active-low request lines, synchronises them, and reports the highest-priority active line (7 highest) as an active-low code.
- Holds the reported code with a valid/ack handshake, then masks the acknowledged line until it releases.
- Cascade pins (ei_n_i, eo_n_o, gs_n_o) keep 74148 semantics, so two instances chain into a 16-line encoder.

Parameters:
- NUM_SYNC_STAGES, 2, flip-flop stages on in_n_i. Legal range 0..3; 0 means bypass with no synchroniser.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- in_n_i  input  8  request lines, active-low; asynchronous to clk_i when NUM_SYNC_STAGES>0.
- ei_n_i  input  1  enable input, active-low; synchronous to clk_i, not synchronised.
- ack_i  input  1  consumer acknowledge of the held code, active-high.
- a_n_o  output  3  encoded index of the granted line, active-low (line k gives ~k).
- gs_n_o  output  1  group select, active-low; low while a code is held.
- eo_n_o  output  1  enable output, active-low; low when enabled, idle and no unmasked request.
- valid_o  output  1  a_n_o holds a valid code awaiting ack.

Behaviour:
- Reset values: a_n_o=3'b111, gs_n_o=1, eo_n_o=1, valid_o=0, mask=8'h00, FSM=IDLE, synchroniser stages all 1 (inactive).
- in_s: in_n_i after NUM_SYNC_STAGES flops.
- req = ~in_s & ~mask, active-high.
- prio: index of the highest set bit of req.
- FSM has two states, IDLE and HOLD.
- IDLE with ei_n_i=0 and req!=0: next cycle go to HOLD.
  - Latch code_q=prio.
  - a_n_o=~code_q, gs_n_o=0, valid_o=1, eo_n_o=1.
- IDLE with ei_n_i=0 and req==0: eo_n_o=0 next cycle; a_n_o=111, gs_n_o=1, valid_o=0.
- IDLE with ei_n_i=1: all outputs inactive next cycle (a_n_o=111, gs_n_o=1, eo_n_o=1, valid_o=0).
- HOLD: a_n_o/gs_n_o/valid_o are frozen.
  - Frozen regardless of in_n_i changes, including release of the granted line.
  - Frozen regardless of higher-priority arrivals.
- HOLD with ack_i=1: IDLE next cycle; valid_o=0, gs_n_o=1, a_n_o=111.
  - mask[code_q] is set, but only if in_s[code_q]==0 that cycle.
  - Earliest next grant is one cycle after return to IDLE, so valid_o is low for at least one cycle between grants.
- HOLD with ei_n_i=1 (abort): IDLE next cycle with outputs inactive. mask is unchanged and the abort is not an ack.
- ack_i and ei_n_i=1 in the same HOLD cycle: ack wins; mask is set as for ack.
- ack_i in IDLE is ignored.
- Mask clear: every cycle, mask[k] clears when in_s[k]==1.
  - If ack set and clear hit the same bit in the same cycle, clear wins.
- Latency from in_n_i falling (stable) to valid_o high: NUM_SYNC_STAGES+1 cycles.
- Latency from ei_n_i change to eo_n_o change: 1 cycle.
- Simultaneous requests: the higher index wins; lower lines stay pending and are granted after each ack.
- Reset asserted mid-HOLD: return to reset values next edge; mask is cleared, so pending lines are re-reported.
- Widths: code_q is 3 bits; no arithmetic apart from the optional counter.

Optional Feature:
- Macro: ENC74148_ACK_COUNT_EN.
- Defined:
  - Adds port ack_cnt_o output 8 bits.
  - Reset value 0.
  - Increments on each accepted ack (HOLD & ack_i).
  - Saturates at 8'hFF, with no wrap.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst_i=1 for 2 cycles, ei_n_i=0, in_n_i=8'hFF → after reset a_n_o=111, gs_n_o=1, valid_o=0, eo_n_o=0 from cycle 1 on.
- Single grant (NUM_SYNC_STAGES=2): ei_n_i=0, in_n_i=8'hDF (line 5) → valid_o=1 exactly 3 cycles later, a_n_o=3'b010, gs_n_o=0, eo_n_o=1. Pulse ack_i → valid_o=0 next cycle and stays 0 while line 5 is held low (masked).
- Priority/pending: in_n_i=8'h6E (lines 7,4,0) → grants 7 (a_n_o=000), then 4 (011), then 0 (111 with gs_n_o=0), one per ack. After the third ack with lines still low, eo_n_o=0.
- Mask release: after acking line 3, drive in_n_i[3]=1 for 1 cycle then 0 → line 3 is re-granted with valid_o=1 at 3 cycles after the fall.
- Abort/enable: in HOLD on line 6, set ei_n_i=1 → next cycle valid_o=0, all outputs high. Restore ei_n_i=0 → line 6 is re-granted (not masked) in the following cycle.
- Mid-op reset and counter: under ENC74148_ACK_COUNT_EN, perform 3 acks → ack_cnt_o=3. Assert rst_i during HOLD → ack_cnt_o=0, valid_o=0, and the held line is re-reported after reset.
